// File: rtl/seq_binary_to_bcd_if.sv
// -----------------------------------------------------------------------------
// seq_binary_to_bcd_if
//   Start/done handshake and result bundle for the sequential binary-to-BCD
//   converter.
//
//   Parameters
//     BIN_W   width of the binary value
//     DIGITS  number of packed BCD digits in the result
//
//   Signals
//     start      requester -> converter  request a conversion (taken when busy=0)
//     bin_in     requester -> converter  value captured on an accepted start
//     busy       converter -> requester  conversion in progress
//     done       converter -> requester  one-cycle pulse, results updated
//     bcd_out    converter -> requester  packed digits, digit 0 = ones
//     overflow   converter -> requester  last result saturated to all nines
//     blank_mask converter -> requester  leading-zero digit flags
//
//   Modports
//     master  the requester (score/timer logic or a testbench)
//     slave   the converter
// -----------------------------------------------------------------------------
interface seq_binary_to_bcd_if #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;
    logic [DIGITS-1:0]     blank_mask;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out,
        input  overflow,
        input  blank_mask
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out,
        output overflow,
        output blank_mask
    );
endinterface

// File: rtl/seq_binary_to_bcd.sv
// -----------------------------------------------------------------------------
// seq_binary_to_bcd
//   Multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble),
//   one input bit per clock. Feeds the seven-segment display driver from wide
//   score/timer counters.
//
//   Parameters
//     BIN_W   width of the unsigned binary input (>= 1)
//     DIGITS  number of BCD digits produced (>= 1)
//
//   Ports
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset; aborts any conversion in flight
//     bus    seq_binary_to_bcd_if.slave: start/bin_in in, busy/done/bcd_out/
//            overflow/blank_mask out (all outputs registered)
//
//   Timing (edge T0 = start accepted)
//     busy high for the BIN_W shift cycles and the done cycle; done pulses in
//     the cycle following the last shift. Start is ignored while busy.
//
//   Optional feature
//     SEQ_BCD_BLANK_EN  when defined, blank_mask flags leading-zero digits
//                       (digit 0 never blanked, mask cleared on overflow);
//                       when undefined, blank_mask is constant zero.
// -----------------------------------------------------------------------------
module seq_binary_to_bcd #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_binary_to_bcd_if.slave   bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // Add-3 correction: any digit >= 5 would become >= 10 after doubling, so
    // it is pre-biased by 3 to make the shift carry into the next digit.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] r;
        r = d;
        for (int k = 0; k < DIGITS; k++) begin
            if (d[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = d[4*k +: 4] + 4'd3;
            end else begin
                r[4*k +: 4] = d[4*k +: 4];
            end
        end
        return r;
    endfunction

`ifdef SEQ_BCD_BLANK_EN
    // Leading-zero flags: digit k (k >= 1) is blank when it and every digit
    // above it are zero. Digit 0 stays visible so a zero value shows "0".
    function automatic logic [DIGITS-1:0] lead_zero_mask(input logic [BCD_W-1:0] d);
        logic [DIGITS-1:0] m;
        logic              all_zero;
        m        = '0;
        all_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            all_zero = all_zero & (d[4*k +: 4] == 4'd0);
            m[k]     = all_zero;
        end
        return m;
    endfunction
`endif

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t             state_r;
    state_t             state_nx;

    logic [BIN_W-1:0]   bin_r;
    logic [BIN_W-1:0]   bin_nx;
    logic [BCD_W-1:0]   dig_r;
    logic [BCD_W-1:0]   dig_nx;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nx;
    logic               ovf_r;
    logic               ovf_nx;

    logic [BCD_W-1:0]   adj_s;
    logic               load_res_s;

    logic               busy_r;
    logic               done_r;
    logic [BCD_W-1:0]   bcd_r;
    logic               overflow_r;
`ifdef SEQ_BCD_BLANK_EN
    logic [DIGITS-1:0]  blank_r;
`endif

    // Next-state and datapath update for the IDLE -> SHIFT -> DONE sequence
    always_comb begin
        state_nx   = state_r;
        bin_nx     = bin_r;
        dig_nx     = dig_r;
        cnt_nx     = cnt_r;
        ovf_nx     = ovf_r;
        load_res_s = 1'b0;
        adj_s      = add3_digits(dig_r);

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nx = ST_SHIFT;
                    bin_nx   = bus.bin_in;
                    dig_nx   = '0;
                    ovf_nx   = 1'b0;
                    cnt_nx   = CNT_W'(BIN_W - 1);
                end else begin
                    state_nx = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                // A set top bit after correction is a carry out of the most
                // significant digit: the value no longer fits in DIGITS.
                dig_nx = {adj_s[BCD_W-2:0], bin_r[BIN_W-1]};
                bin_nx = bin_r << 1;
                ovf_nx = ovf_r | adj_s[BCD_W-1];
                if (cnt_r == '0) begin
                    state_nx   = ST_DONE;
                    load_res_s = 1'b1;
                end else begin
                    state_nx = ST_SHIFT;
                    cnt_nx   = cnt_r - CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_nx = ST_IDLE;
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Scratch registers: captured operand, digit accumulator, bit counter, sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_r <= '0;
            dig_r <= '0;
            cnt_r <= '0;
            ovf_r <= 1'b0;
        end else begin
            bin_r <= bin_nx;
            dig_r <= dig_nx;
            cnt_r <= cnt_nx;
            ovf_r <= ovf_nx;
        end
    end

    // Registered handshake and results; results load on the edge into DONE so
    // they are valid during the done pulse and held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bcd_r      <= '0;
            overflow_r <= 1'b0;
        end else begin
            busy_r <= (state_nx != ST_IDLE);
            done_r <= load_res_s;
            if (load_res_s) begin
                overflow_r <= ovf_nx;
                bcd_r      <= ovf_nx ? {DIGITS{4'h9}} : dig_nx;
            end else begin
                overflow_r <= overflow_r;
                bcd_r      <= bcd_r;
            end
        end
    end

`ifdef SEQ_BCD_BLANK_EN
    // Leading-zero mask, refreshed together with the result; cleared on overflow
    // because a saturated all-nines display has no leading zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_r <= '0;
        end else if (load_res_s) begin
            blank_r <= ovf_nx ? '0 : lead_zero_mask(dig_nx);
        end else begin
            blank_r <= blank_r;
        end
    end

    assign bus.blank_mask = blank_r;
`else
    assign bus.blank_mask = '0;
`endif

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.bcd_out  = bcd_r;
    assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_seq_binary_to_bcd.sv
// -----------------------------------------------------------------------------
// tb_seq_binary_to_bcd
//   Drives a 32-bit/10-digit converter and a 10-bit/3-digit converter.
//   Expected results are pushed into per-DUT queues when a start is driven
//   and popped when done is seen on the falling edge.
// -----------------------------------------------------------------------------
module tb_seq_binary_to_bcd;

    logic clk;
    logic rst_n;

    seq_binary_to_bcd_if #(.BIN_W(32), .DIGITS(10)) b0();
    seq_binary_to_bcd_if #(.BIN_W(10), .DIGITS(3))  b3();

    seq_binary_to_bcd #(.BIN_W(32), .DIGITS(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    seq_binary_to_bcd #(.BIN_W(10), .DIGITS(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b3)
    );

`ifdef SEQ_BCD_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] bin;
        logic [39:0] bcd;
        logic        ovf;
        logic [9:0]  blank_en;   // mask expected when blanking is built in
    } vec_t;

    typedef struct {
        logic [39:0] bcd;
        logic        ovf;
        logic [9:0]  blank;
        int          cyc;        // edge count at which done must be observed
    } exp_t;

    exp_t q0[$];
    exp_t q3[$];

    int total;
    int bad;
    int cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and score any done pulse seen there.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (b0.done === 1'b1) begin
            if (q0.size() == 0) begin
                check("dut0_unexpected_done", 64'd1, 64'd0);
            end else begin
                e = q0.pop_front();
                check("dut0_bcd",      {24'd0, b0.bcd_out},    {24'd0, e.bcd});
                check("dut0_overflow", {63'd0, b0.overflow},   {63'd0, e.ovf});
                check("dut0_blank",    {54'd0, b0.blank_mask}, {54'd0, e.blank});
                check("dut0_latency",  64'(cyc),               64'(e.cyc));
            end
        end
        if (b3.done === 1'b1) begin
            if (q3.size() == 0) begin
                check("dut3_unexpected_done", 64'd1, 64'd0);
            end else begin
                e = q3.pop_front();
                check("dut3_bcd",      {52'd0, b3.bcd_out},    {24'd0, e.bcd});
                check("dut3_overflow", {63'd0, b3.overflow},   {63'd0, e.ovf});
                check("dut3_blank",    {61'd0, b3.blank_mask}, {54'd0, e.blank});
                check("dut3_latency",  64'(cyc),               64'(e.cyc));
            end
        end
    endtask

    // Called just after a falling edge with the DUT idle: accepted at the next
    // rising edge, done expected BIN_W edges after that one.
    task automatic launch0(input vec_t v);
        exp_t e;
        e.bcd   = v.bcd;
        e.ovf   = v.ovf;
        e.blank = BLANK_ON ? v.blank_en : 10'd0;
        e.cyc   = cyc + 1 + 32;
        q0.push_back(e);
        b0.start  = 1'b1;
        b0.bin_in = v.bin;
        step();
        b0.start  = 1'b0;
        b0.bin_in = $urandom;
        check("dut0_busy_after_start", {63'd0, b0.busy}, 64'd1);
    endtask

    task automatic launch3(input vec_t v);
        exp_t e;
        e.bcd   = v.bcd;
        e.ovf   = v.ovf;
        e.blank = BLANK_ON ? v.blank_en : 10'd0;
        e.cyc   = cyc + 1 + 10;
        q3.push_back(e);
        b3.start  = 1'b1;
        b3.bin_in = v.bin[9:0];
        step();
        b3.start  = 1'b0;
        b3.bin_in = 10'($urandom);
        check("dut3_busy_after_start", {63'd0, b3.busy}, 64'd1);
    endtask

    // Step until both scoreboards drain (bounded), then one idle cycle.
    task automatic drain();
        for (int i = 0; i < 80 && (q0.size() != 0 || q3.size() != 0); i++) begin
            step();
        end
        check("drain_timeout", 64'(q0.size() + q3.size()), 64'd0);
        q0.delete();
        q3.delete();
        step();
        check("dut0_idle_busy", {63'd0, b0.busy}, 64'd0);
    endtask

    vec_t tbl0[8];
    vec_t tbl3[5];
    vec_t v;
    int   got;

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;

        tbl0[0] = '{32'd255,        40'h00_0000_0255, 1'b0, 10'b11_1111_1000};
        tbl0[1] = '{32'd0,          40'h00_0000_0000, 1'b0, 10'b11_1111_1110};
        tbl0[2] = '{32'hFFFF_FFFF,  40'h42_9496_7295, 1'b0, 10'b00_0000_0000};
        tbl0[3] = '{32'd42,         40'h00_0000_0042, 1'b0, 10'b11_1111_1100};
        tbl0[4] = '{32'd1000000000, 40'h10_0000_0000, 1'b0, 10'b00_0000_0000};
        tbl0[5] = '{32'd99999,      40'h00_0009_9999, 1'b0, 10'b11_1110_0000};
        tbl0[6] = '{32'd1234,       40'h00_0000_1234, 1'b0, 10'b11_1111_0000};
        tbl0[7] = '{32'd7,          40'h00_0000_0007, 1'b0, 10'b11_1111_1110};

        tbl3[0] = '{32'd1000, 40'h999, 1'b1, 10'b000};
        tbl3[1] = '{32'd999,  40'h999, 1'b0, 10'b000};
        tbl3[2] = '{32'd5,    40'h005, 1'b0, 10'b110};
        tbl3[3] = '{32'd1023, 40'h999, 1'b1, 10'b000};
        tbl3[4] = '{32'd0,    40'h000, 1'b0, 10'b110};

        b0.start = 1'b0; b0.bin_in = '0;
        b3.start = 1'b0; b3.bin_in = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        step();
        step();
        check("reset_busy",     {63'd0, b0.busy},       64'd0);
        check("reset_done",     {63'd0, b0.done},       64'd0);
        check("reset_bcd",      {24'd0, b0.bcd_out},    64'd0);
        check("reset_overflow", {63'd0, b0.overflow},   64'd0);
        check("reset_blank",    {54'd0, b0.blank_mask}, 64'd0);
        rst_n = 1'b1;
        step();

        // Table-driven conversions on both widths in parallel.
        for (int i = 0; i < 8; i++) begin
            launch0(tbl0[i]);
            if (i < 5) begin
                launch3(tbl3[i]);
            end else begin
                step();
            end
            drain();
        end

        // Start held high and bin_in churning during a conversion of 1234:
        // exactly one done, and the held start is taken only on the edge
        // after the done cycle.
        launch0(tbl0[6]);
        got = 0;
        for (int i = 0; i < 60 && got == 0; i++) begin
            if (b0.done === 1'b1) begin
                got = 1;
            end else begin
                b0.start  = 1'b1;
                b0.bin_in = $urandom;
                step();
            end
        end
        check("b2b_first_done_seen", 64'(got), 64'd1);
        v = '{32'd5678, 40'h00_0000_5678, 1'b0, 10'b11_1111_0000};
        begin
            exp_t e;
            e.bcd   = v.bcd;
            e.ovf   = v.ovf;
            e.blank = BLANK_ON ? v.blank_en : 10'd0;
            e.cyc   = cyc + 2 + 32;
            q0.push_back(e);
        end
        b0.start  = 1'b1;
        b0.bin_in = v.bin;
        step();
        check("b2b_idle_gap_busy", {63'd0, b0.busy}, 64'd0);
        step();
        b0.start  = 1'b0;
        b0.bin_in = $urandom;
        check("b2b_second_accepted", {63'd0, b0.busy}, 64'd1);
        drain();

        // Reset in the middle of a conversion: outputs clear at once, no done.
        launch0(tbl0[5]);
        for (int i = 0; i < 9; i++) step();
        rst_n = 1'b0;
        #1;
        check("midrst_busy",     {63'd0, b0.busy},       64'd0);
        check("midrst_done",     {63'd0, b0.done},       64'd0);
        check("midrst_bcd",      {24'd0, b0.bcd_out},    64'd0);
        check("midrst_overflow", {63'd0, b0.overflow},   64'd0);
        check("midrst_blank",    {54'd0, b0.blank_mask}, 64'd0);
        q0.delete();
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) step();
        launch0(tbl0[7]);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
